// File: rtl/mux_4_pkg.sv
// Shared word-select encoding for the 4:1 data mux and cache word-select users.
package mux_4_pkg;

  localparam logic [1:0] SEL_W0 = 2'd0;
  localparam logic [1:0] SEL_W1 = 2'd1;
  localparam logic [1:0] SEL_W2 = 2'd2;
  localparam logic [1:0] SEL_W3 = 2'd3;

endpackage : mux_4_pkg

// File: rtl/mux_4_if.sv
// Bundle of select, data and qualifier signals for a mux_4 instance.
interface mux_4_if #(
  parameter int WIDTH = 32
);

  logic [1:0]       sel;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic             valid;
  logic [WIDTH-1:0] out;
  logic             out_valid;

  modport master (
    output sel, in0, in1, in2, in3, valid,
    input  out, out_valid
  );

  modport slave (
    input  sel, in0, in1, in2, in3, valid,
    output out, out_valid
  );

endinterface : mux_4_if

// File: rtl/mux_4.sv
// 4:1 data mux with a build-time choice of combinational or single-register output.
// An unknown select drives an all-X result rather than falling through to in0_i.
module mux_4
  import mux_4_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit REGISTERED = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       sel_i,
  input  logic [WIDTH-1:0] in0_i,
  input  logic [WIDTH-1:0] in1_i,
  input  logic [WIDTH-1:0] in2_i,
  input  logic [WIDTH-1:0] in3_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] out_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] sel_data_s;

  // Decode the select; the default arm is reachable only for X/Z selects.
  always_comb begin
    sel_data_s = {WIDTH{1'b0}};
    case (sel_i)
      SEL_W0:  sel_data_s = in0_i;
      SEL_W1:  sel_data_s = in1_i;
      SEL_W2:  sel_data_s = in2_i;
      SEL_W3:  sel_data_s = in3_i;
      default: sel_data_s = {WIDTH{1'bx}};
    endcase
  end

  generate
    if (REGISTERED) begin : g_reg
      logic [WIDTH-1:0] out_r;
      logic             valid_r;

      // Capture the selection on valid cycles; hold data otherwise.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          out_r   <= {WIDTH{1'b0}};
          valid_r <= 1'b0;
        end else begin
          valid_r <= valid_i;
          if (valid_i) begin
            out_r <= sel_data_s;
          end else begin
            out_r <= out_r;
          end
        end
      end

      assign out_o   = out_r;
      assign valid_o = valid_r;
    end else begin : g_comb
      // Clock and reset are intentionally inert in the combinational variant.
      logic unused_clk_rst_s;
      assign unused_clk_rst_s = clk_i & rst_ni;

      assign out_o   = sel_data_s;
      assign valid_o = valid_i;
    end
  endgenerate

endmodule : mux_4

// File: tb/tb_mux_4.sv
// Directed bench for mux_4: combinational 32/8-bit instances and a registered 32-bit instance.
module tb_mux_4;
  import mux_4_pkg::*;

  localparam logic [31:0] D0 = 32'h03020100;
  localparam logic [31:0] D1 = 32'h07060504;
  localparam logic [31:0] D2 = 32'h0B0A0908;
  localparam logic [31:0] D3 = 32'h0F0E0D0C;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mux_4_if #(.WIDTH(32)) c_if ();
  mux_4_if #(.WIDTH(32)) r_if ();
  mux_4_if #(.WIDTH(8))  b_if ();

  mux_4 #(.WIDTH(32), .REGISTERED(1'b0)) u_comb (
    .clk_i(clk), .rst_ni(rst_n), .sel_i(c_if.sel),
    .in0_i(c_if.in0), .in1_i(c_if.in1), .in2_i(c_if.in2), .in3_i(c_if.in3),
    .valid_i(c_if.valid), .out_o(c_if.out), .valid_o(c_if.out_valid)
  );

  mux_4 #(.WIDTH(32), .REGISTERED(1'b1)) u_reg (
    .clk_i(clk), .rst_ni(rst_n), .sel_i(r_if.sel),
    .in0_i(r_if.in0), .in1_i(r_if.in1), .in2_i(r_if.in2), .in3_i(r_if.in3),
    .valid_i(r_if.valid), .out_o(r_if.out), .valid_o(r_if.out_valid)
  );

  mux_4 #(.WIDTH(8), .REGISTERED(1'b0)) u_comb8 (
    .clk_i(clk), .rst_ni(rst_n), .sel_i(b_if.sel),
    .in0_i(b_if.in0), .in1_i(b_if.in1), .in2_i(b_if.in2), .in3_i(b_if.in3),
    .valid_i(b_if.valid), .out_o(b_if.out), .valid_o(b_if.out_valid)
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] x8;
    x8 = 8'hxx;

    rst_n = 1'b0;
    c_if.sel = SEL_W0; c_if.valid = 1'b0;
    c_if.in0 = D0; c_if.in1 = D1; c_if.in2 = D2; c_if.in3 = D3;
    r_if.sel = SEL_W0; r_if.valid = 1'b0;
    r_if.in0 = D0; r_if.in1 = D1; r_if.in2 = D2; r_if.in3 = D3;
    b_if.sel = SEL_W0; b_if.valid = 1'b0;
    b_if.in0 = 8'h11; b_if.in1 = 8'h22; b_if.in2 = 8'hA5; b_if.in3 = 8'h44;
    #2;

    // Registered instance in reset.
    check32("reset_out", r_if.out, 32'h0);
    check1("reset_valid", r_if.out_valid, 1'b0);

    // Combinational selection, zero latency, even while reset is asserted.
    c_if.sel = SEL_W0; #1; check32("comb_sel0", c_if.out, D0);
    c_if.sel = SEL_W1; #1; check32("comb_sel1", c_if.out, D1);
    c_if.sel = SEL_W2; #1; check32("comb_sel2", c_if.out, D2);
    c_if.sel = SEL_W3; #1; check32("comb_sel3", c_if.out, D3);
    c_if.valid = 1'b1; #1; check1("comb_valid1", c_if.out_valid, 1'b1);
    c_if.valid = 1'b0; #1; check1("comb_valid0", c_if.out_valid, 1'b0);

    // Release reset, present sel=2; nothing before the edge, captured after.
    @(negedge clk);
    rst_n = 1'b1;
    r_if.sel = SEL_W2; r_if.valid = 1'b1;
    #1;
    check32("pre_edge_out", r_if.out, 32'h0);
    check1("pre_edge_valid", r_if.out_valid, 1'b0);
    @(posedge clk); #1;
    check32("cap_sel2_out", r_if.out, D2);
    check1("cap_sel2_valid", r_if.out_valid, 1'b1);

    // Capture D1 then hold it across three idle cycles with noisy inputs.
    @(negedge clk);
    r_if.sel = SEL_W1;
    @(posedge clk); #1;
    check32("cap_sel1_out", r_if.out, D1);
    @(negedge clk);
    r_if.valid = 1'b0; r_if.sel = SEL_W3;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check32($sformatf("hold_out_%0d", i), r_if.out, D1);
      check1($sformatf("hold_valid_%0d", i), r_if.out_valid, 1'b0);
    end

    // Mid-cycle input changes do not reach the registered output.
    r_if.sel = SEL_W0; r_if.in1 = 32'h12345678; #2;
    check32("midcycle_out", r_if.out, D1);
    r_if.in1 = D1;

    // Back-to-back valid cycles with sel 3,0,1.
    @(negedge clk); r_if.valid = 1'b1; r_if.sel = SEL_W3;
    @(posedge clk); #1; check32("b2b_sel3", r_if.out, D3);
    check1("b2b_valid", r_if.out_valid, 1'b1);
    @(negedge clk); r_if.sel = SEL_W0;
    @(posedge clk); #1; check32("b2b_sel0", r_if.out, D0);
    @(negedge clk); r_if.sel = SEL_W1;
    @(posedge clk); #1; check32("b2b_sel1", r_if.out, D1);

    // Select and data change together: new select with new data.
    @(negedge clk); r_if.sel = SEL_W2; r_if.in2 = 32'hDEADBEEF;
    @(posedge clk); #1; check32("sel_data_same_cycle", r_if.out, 32'hDEADBEEF);

    // Asynchronous reset between edges; comb instance is unaffected.
    c_if.sel = SEL_W1; c_if.valid = 1'b1;
    #2; rst_n = 1'b0; #1;
    check32("async_rst_out", r_if.out, 32'h0);
    check1("async_rst_valid", r_if.out_valid, 1'b0);
    check32("comb_rst_out", c_if.out, D1);
    check1("comb_rst_valid", c_if.out_valid, 1'b1);
    @(posedge clk); #1;
    check32("in_rst_edge_out", r_if.out, 32'h0);

    // First capture after release needs valid_i=1.
    @(negedge clk); rst_n = 1'b1; r_if.valid = 1'b0; r_if.sel = SEL_W3;
    @(posedge clk); #1;
    check32("post_rst_idle_out", r_if.out, 32'h0);
    check1("post_rst_idle_valid", r_if.out_valid, 1'b0);
    @(negedge clk); r_if.valid = 1'b1;
    @(posedge clk); #1;
    check32("post_rst_cap_out", r_if.out, D3);
    check1("post_rst_cap_valid", r_if.out_valid, 1'b1);

    // 8-bit combinational instance.
    b_if.sel = SEL_W2; #1; check8("w8_sel2", b_if.out, 8'hA5);
    b_if.sel = SEL_W3; #1; check8("w8_sel3", b_if.out, 8'h44);
    b_if.sel = 2'bxx; #1;
    if ($isunknown(b_if.sel)) begin
      check8("w8_sel_x", b_if.out, x8);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mux_4
